uart_color_msg_decoder: RTL

- Receive end of the colour-report link: takes the 8N1 serial line carrying 12-byte ASCII frames "SI-SIM1-<c>-#\n" and recovers the colour code.
- Letters map as P=RED, N=GREEN, W=BLUE.
- Sits on the base-station or host-side FPGA, downstream of the rover's colour transmitter.
- Emits a validated colour code with a one-cycle strobe, and flags malformed frames.

---
 rtl/uart_color_pkg.sv | 39 +++
 rtl/uart_rx_byte.sv | 79 +++++++
 rtl/uart_color_msg_decoder.sv | 69 ++++++
 3 files changed

// File: rtl/uart_color_pkg.sv
// uart_color_pkg: colour codes, frame template and helpers for the colour-report link
package uart_color_pkg;
    localparam int MSG_LEN = 12;
    localparam logic [1:0] RED   = 2'b00;
    localparam logic [1:0] GREEN = 2'b01;
    localparam logic [1:0] BLUE  = 2'b10;
    localparam logic [1:0] WHITE = 2'b11;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_I    = 8'h49;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_M    = 8'h4D;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_N    = 8'h4E;
    localparam logic [7:0] CH_W    = 8'h57;

    // Index 8 carries the colour letter and is checked separately.
    function automatic logic [7:0] template_byte(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd3: return CH_S;
            4'd1, 4'd4: return CH_I;
            4'd2, 4'd7, 4'd9: return CH_DASH;
            4'd5: return CH_M;
            4'd6: return CH_1;
            4'd10: return CH_HASH;
            4'd11: return CH_LF;
            default: return 8'h00;
        endcase
    endfunction

    // Returns {known_letter, code}.
    function automatic logic [2:0] letter_code(input logic [7:0] b);
        return (b == CH_P) ? {1'b1, RED} :
               (b == CH_N) ? {1'b1, GREEN} :
               (b == CH_W) ? {1'b1, BLUE} : {1'b0, WHITE};
    endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop synchroniser plus 8N1 receive FSM with mid-bit sampling
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [1:0]    rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync    <= 2'b11;
            rx_prev    <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_sync    <= {rx_sync[0], rx};
            rx_prev    <= rx_sync[1];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: if (rx_prev && !rx_sync[1]) begin
                    state <= START;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                START: if (cnt == HALF) begin
                    cnt <= '0;
                    if (rx_sync[1]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= DATA;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DATA: if (cnt == FULL) begin
                    cnt     <= '0;
                    data    <= {rx_sync[1], data[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                STOP: if (cnt == FULL) begin
                    cnt        <= '0;
                    state      <= IDLE;
                    busy       <= 1'b0;
                    byte_valid <= rx_sync[1];
                    frame_err  <= !rx_sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_color_msg_decoder.sv
// uart_color_msg_decoder: parses "SI-SIM1-<c>-#\n" frames from the serial line
// into a held colour code with valid/error strobes.
module uart_color_msg_decoder
    import uart_color_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [1:0] color_code,
    output logic       msg_valid,
    output logic       msg_err,
    output logic       busy
);
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] data;
    logic [3:0] idx;
    logic [1:0] pending;
    logic [2:0] letter;
    logic       match;
    logic       last;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .byte_valid(byte_valid),
        .data(data),
        .frame_err(frame_err),
        .busy(busy)
    );

    always_comb begin
        letter = letter_code(data);
        match  = (idx == 4'd8) ? letter[2] : (data == template_byte(idx));
        last   = idx == 4'(MSG_LEN - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_code <= WHITE;
            msg_valid  <= 1'b0;
            msg_err    <= 1'b0;
            idx        <= '0;
            pending    <= WHITE;
        end else begin
            msg_valid <= 1'b0;
            msg_err   <= frame_err;
            if (frame_err) begin
                idx <= '0;
            end else if (byte_valid) begin
                if (match) begin
                    if (idx == 4'd8) pending <= letter[1:0];
                    idx <= last ? 4'd0 : idx + 1'b1;
                    if (last) begin
                        color_code <= pending;
                        msg_valid  <= 1'b1;
                    end
                end else begin
                    // A stray 'S' may be the start of a new frame.
                    msg_err <= 1'b1;
                    idx     <= (data == CH_S) ? 4'd1 : 4'd0;
                end
            end
        end
    end
endmodule
